// File: rtl/tel_param.sv
// tel_param: call-session controller (idle/ringing/talk/cost) with scrolling ASCII display and saturating cost.
// Optional build macro TEL_TIME_CHARGE_EN adds a one-unit charge for every cycle spent talking.
module tel_param #(
  parameter int unsigned MSG_CHARS     = 32'd8,
  parameter int unsigned COST_PER_CHAR = 32'd2,
  parameter int unsigned RING_TIMEOUT  = 32'd10,
  parameter int unsigned HOLD_CYCLES   = 32'd5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startCall,
  input  logic                   answerCall,
  input  logic                   endCall,
  input  logic                   sendChar,
  input  logic [7:0]             charSent,
  output logic [8*MSG_CHARS-1:0] statusMsg,
  output logic [8*MSG_CHARS-1:0] sentMsg,
  output logic [4*MSG_CHARS-1:0] cost
);

  localparam int unsigned COST_W = 4*MSG_CHARS;
  localparam int unsigned MSG_W  = 8*MSG_CHARS;
  localparam int unsigned RING_W = (RING_TIMEOUT > 32'd1) ? $clog2(RING_TIMEOUT) : 32'd1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 32'd1;

  localparam logic [COST_W:0]   CHAR_INC  = (COST_W+1)'(COST_PER_CHAR);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [MSG_W-1:0]  BLANK     = {MSG_CHARS{8'h20}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RINGING  = 3'd1,
    ST_CALL     = 3'd2,
    ST_REJECTED = 3'd3,
    ST_BUSY     = 3'd4,
    ST_COST     = 3'd5
  } state_t;

  function automatic logic [7:0] hexDigit(input logic [3:0] nib);
    if (nib < 4'd10) begin
      hexDigit = 8'h30 + {4'h0, nib};
    end else begin
      hexDigit = 8'h37 + {4'h0, nib};
    end
  endfunction

  // Cost rendered MSB first; COST_W is exactly four bits per display character.
  function automatic logic [MSG_W-1:0] costToHex(input logic [COST_W-1:0] val);
    logic [MSG_W-1:0] txt;
    txt = BLANK;
    for (int unsigned i = 0; i < MSG_CHARS; i++) begin
      txt[8*i +: 8] = hexDigit(val[4*i +: 4]);
    end
    return txt;
  endfunction

  function automatic logic [MSG_W-1:0] statusText(input state_t st);
    logic [63:0]      name;
    logic [MSG_W-1:0] txt;
    case (st)
      ST_IDLE:     name = "IDLE    ";
      ST_RINGING:  name = "RINGING ";
      ST_CALL:     name = "CALL    ";
      ST_REJECTED: name = "REJECTED";
      ST_BUSY:     name = "BUSY    ";
      ST_COST:     name = "COST    ";
      default:     name = "IDLE    ";
    endcase
    txt = BLANK;
    txt[MSG_W-1 -: 64] = name;
    return txt;
  endfunction

  state_t              state_r;
  state_t              nextState_s;
  logic [RING_W-1:0]   ringCnt_r;
  logic [HOLD_W-1:0]   holdCnt_r;
  logic [COST_W-1:0]   cost_r;
  logic [MSG_W-1:0]    sentMsg_r;
  logic [MSG_W-1:0]    statusMsg_r;
  logic                ringDone_s;
  logic                holdDone_s;
  logic                holdState_s;
  logic                printable_s;
  logic                clearRun_s;
  logic                acceptChar_s;
  logic                loadHex_s;
  logic                blankMsg_s;
  logic                inCall_s;
  logic [COST_W:0]     costSum_s;
  logic [COST_W-1:0]   costNext_s;
`ifdef TEL_TIME_CHARGE_EN
  logic                timeCharge_s;
`endif

  assign ringDone_s  = (ringCnt_r == RING_LAST);
  assign holdDone_s  = (holdCnt_r == HOLD_LAST);
  assign printable_s = (charSent >= 8'd32) && (charSent <= 8'd126);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state logic; in RINGING endCall beats answerCall beats the timeout.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (startCall) nextState_s = ST_RINGING;
        else           nextState_s = ST_IDLE;
      end
      ST_RINGING: begin
        if (endCall)         nextState_s = ST_REJECTED;
        else if (answerCall) nextState_s = ST_CALL;
        else if (ringDone_s) nextState_s = ST_BUSY;
        else                 nextState_s = ST_RINGING;
      end
      ST_CALL: begin
        if (endCall) nextState_s = ST_COST;
        else         nextState_s = ST_CALL;
      end
      ST_REJECTED, ST_BUSY, ST_COST: begin
        if (holdDone_s) nextState_s = ST_IDLE;
        else            nextState_s = state_r;
      end
      default: nextState_s = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state and sampled inputs.
  always_comb begin
    clearRun_s   = 1'b0;
    acceptChar_s = 1'b0;
    loadHex_s    = 1'b0;
    blankMsg_s   = 1'b0;
    holdState_s  = 1'b0;
    inCall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clearRun_s = startCall;
        blankMsg_s = startCall;
      end
      ST_CALL: begin
        inCall_s     = 1'b1;
        acceptChar_s = sendChar && printable_s && !endCall;
        loadHex_s    = endCall;
      end
      ST_REJECTED, ST_BUSY: begin
        holdState_s = 1'b1;
      end
      ST_COST: begin
        holdState_s = 1'b1;
        blankMsg_s  = holdDone_s;
      end
      default: begin
        clearRun_s = 1'b0;
      end
    endcase
  end

`ifdef TEL_TIME_CHARGE_EN
  assign timeCharge_s = inCall_s && !endCall;
`endif

  // Cost adder, one bit wider than the cost so overflow can be clamped.
  always_comb begin
    costSum_s = {1'b0, cost_r};
    if (acceptChar_s) begin
      costSum_s = costSum_s + CHAR_INC;
    end else begin
      costSum_s = costSum_s;
    end
`ifdef TEL_TIME_CHARGE_EN
    if (timeCharge_s) begin
      costSum_s = costSum_s + {{COST_W{1'b0}}, 1'b1};
    end else begin
      costSum_s = costSum_s;
    end
`endif
    if (costSum_s[COST_W]) begin
      costNext_s = {COST_W{1'b1}};
    end else begin
      costNext_s = costSum_s[COST_W-1:0];
    end
  end

  // Ring and hold counters restart whenever their state is entered or left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ringCnt_r <= {RING_W{1'b0}};
      holdCnt_r <= {HOLD_W{1'b0}};
    end else begin
      if ((state_r == ST_RINGING) && (nextState_s == ST_RINGING)) begin
        ringCnt_r <= ringCnt_r + RING_W'(1);
      end else begin
        ringCnt_r <= {RING_W{1'b0}};
      end
      if (holdState_s && (nextState_s == state_r)) begin
        holdCnt_r <= holdCnt_r + HOLD_W'(1);
      end else begin
        holdCnt_r <= {HOLD_W{1'b0}};
      end
    end
  end

  // Cost register; it survives the COST and IDLE states until the next call starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cost_r <= {COST_W{1'b0}};
    end else if (clearRun_s) begin
      cost_r <= {COST_W{1'b0}};
    end else if (inCall_s) begin
      cost_r <= costNext_s;
    end else begin
      cost_r <= cost_r;
    end
  end

  // Message display: blank, hex cost snapshot, or left-scrolling character shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sentMsg_r <= BLANK;
    end else if (blankMsg_s) begin
      sentMsg_r <= BLANK;
    end else if (loadHex_s) begin
      sentMsg_r <= costToHex(cost_r);
    end else if (acceptChar_s) begin
      sentMsg_r <= {sentMsg_r[MSG_W-9:0], charSent};
    end else begin
      sentMsg_r <= sentMsg_r;
    end
  end

  // Status text registered alongside the state it names.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statusMsg_r <= statusText(ST_IDLE);
    end else begin
      statusMsg_r <= statusText(nextState_s);
    end
  end

  assign statusMsg = statusMsg_r;
  assign sentMsg   = sentMsg_r;
  assign cost      = cost_r;

endmodule

// File: tb/tb_tel_param.sv
// Directed self-checking bench for tel_param: a default instance plus a large-rate instance for saturation.
module tb_tel_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startCall = 1'b0;
  logic        answerCall = 1'b0;
  logic        endCall = 1'b0;
  logic        sendChar = 1'b0;
  logic [7:0]  charSent = 8'h00;
  logic [63:0] statusMsg, sentMsg, satStatusMsg, satSentMsg;
  logic [31:0] cost, satCost;

  int nCompared = 0;
  int nMismatched = 0;

  tel_param dut (
    .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
    .endCall(endCall), .sendChar(sendChar), .charSent(charSent),
    .statusMsg(statusMsg), .sentMsg(sentMsg), .cost(cost)
  );

  tel_param #(.COST_PER_CHAR(32'h80000000)) dutSat (
    .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
    .endCall(endCall), .sendChar(sendChar), .charSent(charSent),
    .statusMsg(satStatusMsg), .sentMsg(satSentMsg), .cost(satCost)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic holdTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendOne(input logic [7:0] c);
    sendChar = 1'b1;
    charSent = c;
    tick();
    sendChar = 1'b0;
    charSent = 8'h00;
  endtask

  task automatic pulseStart();
    startCall = 1'b1; tick(); startCall = 1'b0;
  endtask

  task automatic pulseAnswer();
    answerCall = 1'b1; tick(); answerCall = 1'b0;
  endtask

  task automatic pulseEnd();
    endCall = 1'b1; tick(); endCall = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b0;
    #1;
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL reset_status: got '%s' want '%s'", statusMsg, "IDLE    "); end
    nCompared++;
    if (sentMsg !== "        ") begin nMismatched++; $display("FAIL reset_sentMsg: got '%s' want all spaces", sentMsg); end
    nCompared++;
    if (cost !== 32'd0) begin nMismatched++; $display("FAIL reset_cost: got %h want %h", cost, 32'd0); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_call();
    pulseStart();
    nCompared++;
    if (statusMsg !== "RINGING ") begin nMismatched++; $display("FAIL basic_ringing: got '%s' want '%s'", statusMsg, "RINGING "); end
    holdTicks(2);
    pulseAnswer();
    nCompared++;
    if (statusMsg !== "CALL    ") begin nMismatched++; $display("FAIL basic_call: got '%s' want '%s'", statusMsg, "CALL    "); end
    sendOne("W");
    sendOne("h");
    sendOne(8'd135);
    nCompared++;
    if (sentMsg !== "      Wh") begin nMismatched++; $display("FAIL basic_shift: got '%s' want '%s'", sentMsg, "      Wh"); end
    nCompared++;
    if (cost !== 32'd4) begin nMismatched++; $display("FAIL basic_cost: got %h want %h", cost, 32'd4); end
    pulseEnd();
    nCompared++;
    if (statusMsg !== "COST    ") begin nMismatched++; $display("FAIL basic_cost_state: got '%s' want '%s'", statusMsg, "COST    "); end
    nCompared++;
    if (sentMsg !== "00000004") begin nMismatched++; $display("FAIL basic_cost_hex: got '%s' want '%s'", sentMsg, "00000004"); end
    holdTicks(4);
    nCompared++;
    if (statusMsg !== "COST    ") begin nMismatched++; $display("FAIL basic_hold4: got '%s' want '%s'", statusMsg, "COST    "); end
    tick();
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL basic_hold5_idle: got '%s' want '%s'", statusMsg, "IDLE    "); end
    nCompared++;
    if (sentMsg !== "        ") begin nMismatched++; $display("FAIL basic_idle_blank: got '%s' want all spaces", sentMsg); end
    nCompared++;
    if (cost !== 32'd4) begin nMismatched++; $display("FAIL basic_cost_kept: got %h want %h", cost, 32'd4); end
  endtask

  task automatic test_long_message();
    logic [8*23-1:0] text;
    text = "Who is this?Your TA.OK.";
    pulseStart();
    pulseAnswer();
    for (int i = 0; i < 23; i++) sendOne(text[8*(22-i) +: 8]);
    nCompared++;
    if (sentMsg !== "r TA.OK.") begin nMismatched++; $display("FAIL long_scroll: got '%s' want '%s'", sentMsg, "r TA.OK."); end
    nCompared++;
    if (cost !== 32'd46) begin nMismatched++; $display("FAIL long_cost: got %h want %h", cost, 32'd46); end
    pulseEnd();
    nCompared++;
    if (sentMsg !== "0000002E") begin nMismatched++; $display("FAIL long_hex: got '%s' want '%s'", sentMsg, "0000002E"); end
    holdTicks(5);
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL long_idle: got '%s' want '%s'", statusMsg, "IDLE    "); end
  endtask

  task automatic test_busy();
    answerCall = 1'b1; endCall = 1'b1; sendChar = 1'b1; charSent = "Z";
    tick();
    answerCall = 1'b0; endCall = 1'b0; sendChar = 1'b0; charSent = 8'h00;
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL idle_ignore_status: got '%s' want '%s'", statusMsg, "IDLE    "); end
    nCompared++;
    if (cost !== 32'd46) begin nMismatched++; $display("FAIL idle_ignore_cost: got %h want %h", cost, 32'd46); end
    pulseStart();
    nCompared++;
    if (cost !== 32'd0) begin nMismatched++; $display("FAIL busy_cost_clear: got %h want %h", cost, 32'd0); end
    sendOne("Q");
    holdTicks(8);
    nCompared++;
    if (statusMsg !== "RINGING ") begin nMismatched++; $display("FAIL busy_ring9: got '%s' want '%s'", statusMsg, "RINGING "); end
    nCompared++;
    if (sentMsg !== "        ") begin nMismatched++; $display("FAIL busy_ring_nochar: got '%s' want all spaces", sentMsg); end
    tick();
    nCompared++;
    if (statusMsg !== "BUSY    ") begin nMismatched++; $display("FAIL busy_at10: got '%s' want '%s'", statusMsg, "BUSY    "); end
    holdTicks(4);
    nCompared++;
    if (statusMsg !== "BUSY    ") begin nMismatched++; $display("FAIL busy_hold4: got '%s' want '%s'", statusMsg, "BUSY    "); end
    tick();
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL busy_idle: got '%s' want '%s'", statusMsg, "IDLE    "); end
    nCompared++;
    if (cost !== 32'd0) begin nMismatched++; $display("FAIL busy_cost: got %h want %h", cost, 32'd0); end
  endtask

  task automatic test_reject();
    pulseStart();
    tick();
    endCall = 1'b1; answerCall = 1'b1;
    tick();
    endCall = 1'b0; answerCall = 1'b0;
    nCompared++;
    if (statusMsg !== "REJECTED") begin nMismatched++; $display("FAIL reject_state: got '%s' want '%s'", statusMsg, "REJECTED"); end
    holdTicks(4);
    nCompared++;
    if (sentMsg !== "        ") begin nMismatched++; $display("FAIL reject_blank: got '%s' want all spaces", sentMsg); end
    tick();
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL reject_idle: got '%s' want '%s'", statusMsg, "IDLE    "); end
    pulseStart();
    pulseAnswer();
    sendChar = 1'b1; charSent = "A"; endCall = 1'b1;
    tick();
    sendChar = 1'b0; charSent = 8'h00; endCall = 1'b0;
    nCompared++;
    if (statusMsg !== "COST    ") begin nMismatched++; $display("FAIL endwins_state: got '%s' want '%s'", statusMsg, "COST    "); end
    nCompared++;
    if (cost !== 32'd0) begin nMismatched++; $display("FAIL endwins_cost: got %h want %h", cost, 32'd0); end
    nCompared++;
    if (sentMsg !== "00000000") begin nMismatched++; $display("FAIL endwins_hex: got '%s' want '%s'", sentMsg, "00000000"); end
    holdTicks(5);
  endtask

  task automatic test_saturation();
    pulseStart();
    pulseAnswer();
    sendOne("a");
    nCompared++;
    if (satCost !== 32'h80000000) begin nMismatched++; $display("FAIL sat_first: got %h want %h", satCost, 32'h80000000); end
    sendOne("b");
    nCompared++;
    if (satCost !== 32'hFFFFFFFF) begin nMismatched++; $display("FAIL sat_clamp: got %h want %h", satCost, 32'hFFFFFFFF); end
    sendOne("c");
    nCompared++;
    if (satCost !== 32'hFFFFFFFF) begin nMismatched++; $display("FAIL sat_stay: got %h want %h", satCost, 32'hFFFFFFFF); end
    nCompared++;
    if (cost !== 32'd6) begin nMismatched++; $display("FAIL sat_default_cost: got %h want %h", cost, 32'd6); end
    pulseEnd();
    nCompared++;
    if (satSentMsg !== "FFFFFFFF") begin nMismatched++; $display("FAIL sat_hex: got '%s' want '%s'", satSentMsg, "FFFFFFFF"); end
    nCompared++;
    if (sentMsg !== "00000006") begin nMismatched++; $display("FAIL sat_default_hex: got '%s' want '%s'", sentMsg, "00000006"); end
    holdTicks(5);
  endtask

  task automatic test_async_reset();
    pulseStart();
    pulseAnswer();
    sendOne("X");
    sendOne("Y");
    nCompared++;
    if (sentMsg !== "      XY") begin nMismatched++; $display("FAIL areset_pre: got '%s' want '%s'", sentMsg, "      XY"); end
    #3 rst = 1'b0;
    #1;
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL areset_status: got '%s' want '%s'", statusMsg, "IDLE    "); end
    nCompared++;
    if (sentMsg !== "        ") begin nMismatched++; $display("FAIL areset_msg: got '%s' want all spaces", sentMsg); end
    nCompared++;
    if (cost !== 32'd0) begin nMismatched++; $display("FAIL areset_cost: got %h want %h", cost, 32'd0); end
    #2 rst = 1'b1;
    tick();
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL areset_release: got '%s' want '%s'", statusMsg, "IDLE    "); end
  endtask

  task automatic test_time_charge();
    logic [31:0] expCost;
    logic [63:0] expHex;
`ifdef TEL_TIME_CHARGE_EN
    expCost = 32'd10;
    expHex  = "0000000A";
`else
    expCost = 32'd0;
    expHex  = "00000000";
`endif
    pulseStart();
    pulseAnswer();
    holdTicks(10);
    pulseEnd();
    nCompared++;
    if (cost !== expCost) begin nMismatched++; $display("FAIL time_cost: got %h want %h", cost, expCost); end
    nCompared++;
    if (sentMsg !== expHex) begin nMismatched++; $display("FAIL time_hex: got '%s' want '%s'", sentMsg, expHex); end
    holdTicks(5);
    nCompared++;
    if (statusMsg !== "IDLE    ") begin nMismatched++; $display("FAIL time_idle: got '%s' want '%s'", statusMsg, "IDLE    "); end
  endtask

  initial begin
    test_reset();
    test_basic_call();
    test_long_message();
    test_busy();
    test_reject();
    test_saturation();
    test_async_reset();
    test_time_charge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/tel_param.md
Name: tel_param

Overview:
- Parametrised call-session controller for the telephone exchange demo.
- Runs the call state machine (idle, ringing, talk, cost report), shifts printable characters into a scrolling ASCII display and accumulates a saturating call cost.
- Adds three behaviours to the previous generation: a ring timeout ("BUSY"), explicit rejection ("REJECTED"), and a configurable display width, cost rate and hold time.
- Drives the ASCII status and message displays of the board top level.

Parameters:
- MSG_CHARS, 8: display width in characters; must be >= 8. Message buses are 8*MSG_CHARS bits.
- COST_PER_CHAR, 2: cost added per accepted character.
- RING_TIMEOUT, 10: cycles spent in RINGING without an answer before going to BUSY; must be >= 1.
- HOLD_CYCLES, 5: cycles spent in REJECTED, BUSY and COST before returning to IDLE; must be >= 1.
- Derived (localparam) COST_W = 4*MSG_CHARS: cost width, so the cost exactly fills the display in hex.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- startCall  in  1  caller initiates a call; single-cycle pulse.
- answerCall  in  1  callee accepts the call; pulse.
- endCall  in  1  either party hangs up or rejects; pulse.
- sendChar  in  1  charSent is valid this cycle.
- charSent  in  8  ASCII character.
- statusMsg  out  8*MSG_CHARS  state name in ASCII, left-justified, space-padded.
- sentMsg  out  8*MSG_CHARS  scrolling message, or the cost in hex ASCII.
- cost  out  COST_W  running cost, binary.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, statusMsg="IDLE" plus spaces, sentMsg all spaces (8'h20), cost=0, all counters 0.
- All outputs are registered or decoded from registered state. Inputs sampled at edge N are visible after edge N.

State machine and transitions:
- IDLE
  - startCall -> RINGING; clear cost, ring counter and sentMsg.
  - answerCall, endCall and sendChar are ignored.
- RINGING ("RINGING ")
  - Priority: endCall > answerCall > timeout.
  - endCall -> REJECTED.
  - answerCall -> CALL.
  - Ring counter increments every cycle; when it reaches RING_TIMEOUT-1 with no other event -> BUSY. So BUSY appears RING_TIMEOUT cycles after RINGING was entered.
  - sendChar is ignored.
- CALL ("CALL    ")
  - sendChar with 32 <= charSent <= 126: sentMsg <= {sentMsg[8*MSG_CHARS-9:0], charSent} (new character enters on the right, oldest drops off the left); cost += COST_PER_CHAR.
  - Characters outside 32..126 are ignored: no shift, no cost.
  - endCall -> COST. An endCall in the same cycle as sendChar wins; that character is discarded.
  - startCall and answerCall are ignored.
- REJECTED ("REJECTED"), BUSY ("BUSY    ")
  - Hold counter runs for HOLD_CYCLES cycles, then -> IDLE.
  - sentMsg stays all spaces. All inputs are ignored.
- COST ("COST    ")
  - On entry, sentMsg <= cost as MSG_CHARS uppercase hex ASCII digits, MSB first, zero-padded ('0'-'9' = 8'h30-8'h39, 'A'-'F' = 8'h41-8'h46).
  - Holds for HOLD_CYCLES cycles, then -> IDLE with sentMsg = spaces.
  - cost keeps its value until the next startCall.
  - All inputs are ignored.

Arithmetic:
- cost saturates at all-ones (2^COST_W - 1) and never wraps.
- Saturation is checked on the COST_W+1 bit sum.

Reset mid-operation:
- Asynchronous return to the reset values from any state.
- No partial character shift is allowed.

Optional Feature:
- Macro TEL_TIME_CHARGE_EN.
- Defined:
  - Each cycle spent in CALL adds 1 to cost, saturating, in addition to any character charge in that cycle.
  - The cycle in which endCall is sampled is not charged.
  - The cycle that enters CALL is charged from the first edge after entry.
- Undefined: cost changes only on accepted characters. No time-charge logic is present.

Test Plan (defaults unless stated, TEL_TIME_CHARGE_EN undefined):
1. Reset, startCall, answerCall after 3 cycles; send "W", "h", 135 (invalid); endCall
   -> statusMsg "COST    ", sentMsg "00000004", cost=4; statusMsg "IDLE    " exactly 5 cycles later.
2. Call, then send the 23 valid characters "Who is this?Your TA.OK."; endCall
   -> before endCall: sentMsg "r TA.OK.", cost=46; after endCall: sentMsg "0000002E".
3. startCall, no answer
   -> statusMsg "BUSY    " exactly 10 cycles after RINGING was entered; "IDLE    " 5 cycles later; cost=0.
4. startCall, endCall 2 cycles later -> "REJECTED". In CALL, sendChar "A" and endCall in the same cycle -> cost unchanged, state COST.
5. COST_PER_CHAR=32'h80000000; in CALL send 3 valid characters -> cost=32'hFFFFFFFF; sentMsg in COST "FFFFFFFF".
6. Assert rst=0 mid-CALL between clock edges -> outputs return to reset values immediately. With TEL_TIME_CHARGE_EN: answer, idle 10 cycles, endCall -> cost=10.
